// File: rtl/encoder_drain_if.sv
// rtl/encoder_drain_if.sv - handshake bundle between encoder_drain and its source/sink
//
// Signals:
//   a         source -> block  vector to encode
//   in_valid  source -> block  a is valid
//   in_ready  block  -> source block can accept a
//   s         block  -> sink   index of the bit currently presented
//   out_valid block  -> sink   s/last/zero valid
//   out_ready sink   -> block  sink accepts the current beat
//   last      block  -> sink   final beat for the current vector
//   zero      block  -> sink   captured vector was all-zero
// Modports: slave = encoder_drain side, master = source/sink side.
interface encoder_drain_if #(
  parameter int N  = 8,
  parameter int SW = 3
);
  logic [N-1:0]  a;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] s;
  logic          out_valid;
  logic          out_ready;
  logic          last;
  logic          zero;

  modport slave (
    input  a, in_valid, out_ready,
    output in_ready, s, out_valid, last, zero
  );

  modport master (
    output a, in_valid, out_ready,
    input  in_ready, s, out_valid, last, zero
  );
endinterface

// File: rtl/encoder_drain.sv
// rtl/encoder_drain.sv - captures an N-bit vector and drains its set bits as index beats
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   io     encoder_drain_if.slave: a/in_valid/in_ready input handshake,
//          s/last/zero/out_valid/out_ready output handshake
// Build option: ENC_MSB_FIRST_EN presents the highest set bit first
// (descending indices); undefined presents the lowest set bit first.
// All outputs are decoded from registered state only.
module encoder_drain #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  encoder_drain_if.slave   io
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  mask_q, mask_d;
  logic          zero_q, zero_d;

  logic [SW-1:0] sel_idx;
  logic          one_left;
  logic          in_ready_w;
  logic          out_valid_w;
  logic [SW-1:0] s_w;
  logic          last_w;
  logic          zero_w;

  // Priority select over the remaining mask: the last assignment in loop
  // order wins, so the loop direction picks which end is drained first.
  always_comb begin
    sel_idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (mask_q[i]) sel_idx = SW'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_q[i]) sel_idx = SW'(i);
    end
`endif
  end

  // Exactly one bit remaining: non-zero and clearing the lowest set bit empties it.
  assign one_left = (mask_q != '0) && ((mask_q & (mask_q - N'(1))) == '0);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    zero_d      = zero_q;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    s_w         = '0;
    last_w      = 1'b0;
    zero_w      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready_w = 1'b1;
        if (io.in_valid) begin
          mask_d  = io.a;
          zero_d  = (io.a == '0);
          state_d = BUSY;
        end
      end
      BUSY: begin
        out_valid_w = 1'b1;
        s_w         = sel_idx;
        // A zero capture emits a single terminating beat with s=0.
        last_w      = zero_q || one_left;
        zero_w      = zero_q;
        if (io.out_ready) begin
          mask_d = mask_q & ~(N'(1) << sel_idx);
          if (last_w) begin
            state_d = IDLE;
            mask_d  = '0;
            zero_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      zero_q  <= zero_d;
    end
  end

  assign io.in_ready  = in_ready_w;
  assign io.out_valid = out_valid_w;
  assign io.s         = s_w;
  assign io.last      = last_w;
  assign io.zero      = zero_w;

endmodule

// File: tb/tb_encoder_drain.sv
// tb/tb_encoder_drain.sv - scoreboard bench for encoder_drain with directed vectors
module tb_encoder_drain;

  localparam int N  = 8;
  localparam int SW = 3;

  typedef struct packed {
    logic [SW-1:0] s;
    logic          last;
    logic          zero;
  } beat_t;

  logic clk;
  logic rst_n;

  encoder_drain_if #(.N(N), .SW(SW)) bus ();

  encoder_drain #(.N(N), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  int    n_cmp;
  int    n_err;
  beat_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int s, input bit last, input bit zero);
    beat_t b;
    b.s    = SW'(s);
    b.last = last;
    b.zero = zero;
    sb.push_back(b);
  endtask

  // Called at posedge+1 while the block is idle: one accepted input beat.
  task automatic accept(input logic [N-1:0] vec);
    bus.a        = vec;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (!bus.in_ready && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, int'(bus.in_ready), 1);
  endtask

  // Monitor: pops the scoreboard on every transferred beat and checks
  // that a stalled beat is held unchanged into the next cycle.
  initial begin
    beat_t exp_b;
    beat_t held;
    bit    stall_prev;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (stall_prev)
          check("stall_hold", int'({bus.s, bus.last, bus.zero}), int'(held));
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got s=%0d last=%0d zero=%0d expected no beat at %0t",
                     bus.s, bus.last, bus.zero, $time);
          end else begin
            exp_b = sb.pop_front();
            check("beat_s",    int'(bus.s),    int'(exp_b.s));
            check("beat_last", int'(bus.last), int'(exp_b.last));
            check("beat_zero", int'(bus.zero), int'(exp_b.zero));
          end
        end
        stall_prev = !bus.out_ready;
        held       = {bus.s, bus.last, bus.zero};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.a        = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  int'(bus.in_ready),  1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_s",         int'(bus.s),         0);
    check("rst_last",      int'(bus.last),      0);
    check("rst_zero",      int'(bus.zero),      0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single bit: one beat, latency 1, idle right after
    push(2, 1'b1, 1'b0);
    accept(8'b0000_0100);
    check("single_latency", int'(bus.out_valid), 1);
    check("single_busy",    int'(bus.in_ready),  0);
    @(posedge clk);
    #1;
    check("single_ready_after", int'(bus.in_ready), 1);

    // Three bits on consecutive cycles, back to idle after K beats
`ifdef ENC_MSB_FIRST_EN
    push(7, 1'b0, 1'b0);
    push(5, 1'b0, 1'b0);
    push(0, 1'b1, 1'b0);
`else
    push(0, 1'b0, 1'b0);
    push(5, 1'b0, 1'b0);
    push(7, 1'b1, 1'b0);
`endif
    accept(8'b1010_0001);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("a1_still_busy", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    check("a1_spacing", int'(bus.in_ready), 1);

    // Zero vector: single zero/last beat
    push(0, 1'b1, 1'b1);
    accept(8'h00);
    check("zero_latency", int'(bus.out_valid), 1);
    @(posedge clk);
    #1;
    check("zero_ready_after", int'(bus.in_ready), 1);

    // All ones under toggling backpressure
    for (int i = 0; i < N; i++) begin
`ifdef ENC_MSB_FIRST_EN
      push(N - 1 - i, (i == N - 1), 1'b0);
`else
      push(i, (i == N - 1), 1'b0);
`endif
    end
    accept(8'hFF);
    for (int k = 0; k < 60; k++) begin
      bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      @(posedge clk);
      #1;
      if (bus.in_ready) break;
    end
    bus.out_ready = 1'b1;
    check("ff_drained", int'(bus.in_ready), 1);

    // Reset mid-drain discards the remaining bit
`ifdef ENC_MSB_FIRST_EN
    push(5, 1'b0, 1'b0);
`else
    push(4, 1'b0, 1'b0);
`endif
    accept(8'b0011_0000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_in_ready",  int'(bus.in_ready),  1);
    check("mid_rst_last",      int'(bus.last),      0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_out_valid", int'(bus.out_valid), 0);
    check("post_rst_in_ready",  int'(bus.in_ready),  1);

    // in_valid held high across two vectors: second waits for the idle cycle
`ifdef ENC_MSB_FIRST_EN
    push(1, 1'b0, 1'b0);
    push(0, 1'b1, 1'b0);
`else
    push(0, 1'b0, 1'b0);
    push(1, 1'b1, 1'b0);
`endif
    push(7, 1'b1, 1'b0);
    bus.a        = 8'h03;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 8'h80;
    check("hold_beat0_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    check("hold_beat1_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    check("hold_idle_ready", int'(bus.in_ready),  1);
    check("hold_idle_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("hold_second_valid", int'(bus.out_valid), 1);
    check("hold_second_ready", int'(bus.in_ready),  0);
    wait_idle("hold_drain_timeout", 20);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_drain.md
ENCODER_DRAIN -- requirements
Module: encoder_drain

Interface
REQ-001 Parameter N, default 8, input vector width; SHALL be a power of two, 2..256.
REQ-002 Parameter SW, default 3, index width; SHALL equal log2(N).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a  input  N  bit vector to encode; sampled only on an accepted input beat.
REQ-006 in_valid  input  1  a is valid this cycle.
REQ-007 in_ready  output  1  block can accept a this cycle.
REQ-008 s  output  SW  binary index of the set bit currently presented.
REQ-009 out_valid  output  1  s/last/zero valid this cycle.
REQ-010 out_ready  input  1  sink accepts the current output beat.
REQ-011 last  output  1  final beat for the current input vector.
REQ-012 zero  output  1  captured vector was all-zero; s=0 on that beat.

Function
REQ-013 The block SHALL implement two states: IDLE and BUSY.
REQ-014 IDLE: in_ready=1, out_valid=0; s, last, zero SHALL be 0.
REQ-015 Input accept: in_valid && in_ready at a rising edge; a SHALL be captured into an internal N-bit mask, and state SHALL move to BUSY.
REQ-016 BUSY: in_ready=0, out_valid=1; input acceptance SHALL be blocked for the whole drain.
REQ-017 First output beat SHALL be presented the cycle after accept (latency 1 cycle).
REQ-018 In BUSY, s SHALL be the index of the lowest set mask bit (default order; see REQ-029).
REQ-019 last SHALL be 1 when exactly one mask bit remains, or when the captured vector was zero.
REQ-020 Output beat transfer: out_valid && out_ready at a rising edge; the presented bit SHALL be cleared from the mask.
REQ-021 When the transferred beat has last=1, state SHALL return to IDLE; in_ready SHALL be 1 the next cycle.
REQ-022 Zero vector: exactly one beat SHALL be emitted, with zero=1, last=1, s=0.
REQ-023 Backpressure: while out_valid && !out_ready, s, last, zero and the mask SHALL hold stable.
REQ-024 An input vector with K set bits (K>=1) SHALL produce exactly K beats with strictly ordered, distinct indices.
REQ-025 Peak throughput: one beat per cycle while out_ready=1.
REQ-026 Input-to-input spacing SHALL be K+1 cycles minimum: K beats plus one IDLE cycle.
REQ-027 All outputs SHALL be registered or decoded from registered state only; no combinational path from a or out_ready to any output.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, mask=0, out_valid=0, in_ready=1, s=0, last=0, zero=0.
- Reset mid-drain SHALL discard the remaining mask bits and emit no further beats.
- First accept after reset release: first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-029 Macro ENC_MSB_FIRST_EN:
- Defined: BUSY SHALL present the highest set mask bit first (descending indices).
- Undefined: BUSY presents the lowest set mask bit first (ascending indices).
- last and zero behaviour SHALL be identical in both builds.

Verification
REQ-030 a=8'b0000_0100, out_ready=1 -> single beat s=2, last=1, zero=0, one cycle after accept; in_ready high the following cycle.
REQ-031 a=8'b1010_0001, out_ready=1 -> beats s=0,5,7 on consecutive cycles, last only on s=7 (ENC_MSB_FIRST_EN: s=7,5,0, last on s=0).
REQ-032 a=8'h00 -> one beat s=0, zero=1, last=1.
REQ-033 a=8'hFF with out_ready toggling 1,0,0,1,... -> s/last held through stall cycles; 8 beats s=0..7 total, no duplicates or drops.
REQ-034 a=8'b0011_0000 accepted, rst_n pulsed low after first beat (s=4) -> out_valid=0 immediately; no s=5 beat; in_ready=1.
REQ-035 in_valid held high with a=8'h03 then a=8'h80 -> second vector accepted only after last beat of first; beats s=0,1, idle cycle, then s=7.
